sample_source: RTL and testbench
================================

// Module: sample_source
// PURPOSE
// - Producer/responder end of the req/ack sample handshake consumed by the rate-conversion filter.
// - Buffers samples from an upstream valid/ready stream in a small FIFO.
// - Answers each filter request (req) with ack plus one sample (data_out), in order.
// - Sits between the test/ADC sample stream and the filter input port.
// PARAMETERS
// - DWIDTH     16  sample width, signed two's complement
// - DEPTH_LOG  2   FIFO depth = 2**DEPTH_LOG entries (default 4)
// PORTS
// - clk        in   1           system clock, all logic on posedge
// - rst        in   1           synchronous, active-high reset
// - in_valid   in   1           upstream sample valid
// - in_ready   out  1           upstream may push; push = in_valid && in_ready at posedge
// - in_data    in   [0:DWIDTH-1] upstream sample, bit 0 = MSB
// - req        in   1           filter requests one sample
// - ack        out  1           sample on data_out is valid; transfer = req && ack at posedge
// - data_out   out  [0:DWIDTH-1] sample presented to filter, bit 0 = MSB
// - level      out  DEPTH_LOG+1 FIFO occupancy, 0..2**DEPTH_LOG
// - underrun   out  1           sticky: req seen while FIFO empty in IDLE
// BEHAVIOUR
// - Reset values: ack=0, data_out=0, in_ready=1, level=0, underrun=0; FIFO emptied, FSM=IDLE.
// - All outputs registered except in_ready = (level != 2**DEPTH_LOG).
// - FSM states:
//   - IDLE: ack=0. If req && level!=0, load data_out <= FIFO head, ack<=1, pop head, go ACK.
//     If req && level==0, set underrun, stay IDLE.
//   - ACK: ack=1, data_out held stable.
//     - req=1 at posedge = transfer: ack<=0, go REL.
//     - req=0 = withdrawn, no transfer: ack<=0, go IDLE. The popped sample is lost; also set underrun.
//     - The requester never withdraws; this case exists for robustness only.
//   - REL: ack=0. Wait for req=0, then IDLE. Never re-ack while req is still high from the last transfer.
// - Latency: req high at posedge t with non-empty FIFO gives ack=1 after posedge t.
//   One transfer per request; min 3 cycles per sample (IDLE, ACK, REL).
// - Pop occurs on IDLE->ACK (head moves into data_out register).
//   A push in the same cycle is accepted if not full; level = level + push - pop.
// - Full: in_ready=0 and in_data is ignored, even if a pop happens that cycle (no same-cycle bypass).
// - Empty: no ack. A sample pushed at posedge t is poppable at posedge t+1 (no fall-through).
// - Pointers wrap modulo 2**DEPTH_LOG; level has one extra bit to distinguish full from empty.
// - underrun clears only on rst.
// - Reset mid-transfer (any state): next cycle ack=0 and FIFO empty; in-flight sample discarded.
// - data_out is not modified outside IDLE->ACK; value sign/width passed through unchanged.
// STRUCTURE
// - Shared package: state enum {IDLE, ACK, REL}; default DWIDTH; handshake transfer predicate.
//   The filter uses the same predicate.
// - Sub-module: sync_fifo (DWIDTH, DEPTH_LOG).
//   - Ports: push/pop/wdata/rdata/level/full/empty, synchronous reset.
//   - Registered read: rdata valid the cycle pop is asserted.
// - Top: FSM + output registers + underrun flag, about 150-250 lines total.
// TESTING
// - Reset: hold rst 2 cycles -> ack=0, data_out=0, in_ready=1, level=0, underrun=0.
// - Order: push 0x0001, 0x7FFF, 0x8000. Drive req like the filter: raise req, drop after transfer.
//   Expect ack 1 cycle after req; data_out 0x0001, 0x7FFF, 0x8000 in order.
//   ack low the cycle after each transfer.
// - Underrun: req=1 with empty FIFO for 5 cycles -> ack=0, underrun=1.
//   Push 0x1234 -> ack=1, data_out=0x1234 two cycles after the push. underrun stays 1.
// - Full: push 5 samples with req=0 -> level=4, in_ready=0, 5th sample dropped.
//   Request while pushing at full -> level 4->3, pending push not taken.
// - Reset mid-ACK: rst while ack=1, level=2 -> next cycle ack=0, level=0, no transfer counted.
// - Soak: connect to the filter model (L=160, M=147); stream 1000 random samples with random in_valid gaps.
//   All samples are delivered in order; no duplicate acks; never ack while in REL.

Source files
------------

// File: rtl/sample_source_pkg.sv
// Shared definitions for the sample req/ack handshake between sample_source and the rate-conversion filter.
package sample_source_pkg;

    localparam int DWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

    // A sample changes hands on any posedge where both sides are high; the filter uses the same rule.
    function automatic logic hs_transfer(input logic req, input logic ack);
        return req & ack;
    endfunction

endpackage

// File: rtl/sample_source_sync_fifo.sv
// Small synchronous FIFO. The head entry is always visible on rdata, so the consumer registers it on the pop edge.
module sync_fifo #(
    parameter int DWIDTH    = 16,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [0:DWIDTH-1]    wdata,
    output logic [0:DWIDTH-1]    rdata,
    output logic [DEPTH_LOG:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [0:DWIDTH-1]    mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level == (DEPTH_LOG+1)'(DEPTH));
    assign empty   = (level == '0);
    // A push at full is dropped even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_source.sv
// Buffers an upstream valid/ready sample stream and answers each filter req with one ack and one sample, in order.
//
// state | meaning
// IDLE  | ack low; pop the FIFO head into data_out on req when not empty
// ACK   | ack high, data_out stable; req high transfers, req low drops the sample
// REL   | ack low; wait for req to fall so one request never gets two acks
module sample_source
    import sample_source_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:DWIDTH-1]    in_data,
    input  logic                 req,
    output logic                 ack,
    output logic [0:DWIDTH-1]    data_out,
    output logic [DEPTH_LOG:0]   level,
    output logic                 underrun
);

    hs_state_t         state;
    hs_state_t         state_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [0:DWIDTH-1] fifo_rdata;
    logic              ack_next;
    logic              set_underrun;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .DWIDTH    (DWIDTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= 1'b0;
            data_out <= '0;
            underrun <= 1'b0;
        end else begin
            state <= state_next;
            ack   <= ack_next;
            if (fifo_pop) begin
                data_out <= fifo_rdata;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !fifo_empty) state_next = ACK;
            ACK:     state_next = hs_transfer(req, ack) ? REL : IDLE;
            REL:     if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A withdrawn request in ACK loses the already-popped sample, so it counts as an underrun too.
    always_comb begin
        fifo_pop     = (state == IDLE) && req && !fifo_empty;
        set_underrun = ((state == IDLE) && req && fifo_empty) ||
                       ((state == ACK) && !req);
        ack_next     = (state_next == ACK);
    end

endmodule

// File: tb/tb_sample_source.sv
// Bench for sample_source: directed vector table followed by a randomized soak against a queue-based model.
module tb_sample_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] in_data;
    logic        req;
    logic        ack;
    logic [0:15] data_out;
    logic [2:0]  level;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    sample_source #(.DWIDTH(16), .DEPTH_LOG(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req      (req),
        .ack      (ack),
        .data_out (data_out),
        .level    (level),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        rq;
        logic        e_ack;
        logic [15:0] e_data;
        logic [2:0]  e_lvl;
        logic        e_rdy;
        logic        e_und;
    } vec_t;

    vec_t vt[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [15:0] d, input logic rq,
                       input logic ea, input logic [15:0] ed, input logic [2:0] el,
                       input logic er, input logic eu);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.rq = rq;
        v.e_ack = ea; v.e_data = ed; v.e_lvl = el; v.e_rdy = er; v.e_und = eu;
        vt.push_back(v);
    endtask

    // soak model state
    logic [15:0] q[$];
    logic [15:0] exp_d;
    logic        m_und;
    logic        m_pop;
    logic        m_push;
    int          acc;
    int          rq_st;
    int          pushed;
    int          got;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; req = 1'b0;

        // reset
        add(1,0,16'h0000,0, 0,16'h0000,0,1,0);
        add(1,0,16'h0000,0, 0,16'h0000,0,1,0);
        // ordered delivery of edge values
        add(0,1,16'h0001,0, 0,16'h0000,1,1,0);
        add(0,1,16'h7FFF,0, 0,16'h0000,2,1,0);
        add(0,1,16'h8000,0, 0,16'h0000,3,1,0);
        add(0,0,16'h0000,1, 1,16'h0001,2,1,0);
        add(0,0,16'h0000,1, 0,16'h0001,2,1,0);
        add(0,0,16'h0000,0, 0,16'h0001,2,1,0);
        add(0,0,16'h0000,1, 1,16'h7FFF,1,1,0);
        add(0,0,16'h0000,1, 0,16'h7FFF,1,1,0);
        add(0,0,16'h0000,0, 0,16'h7FFF,1,1,0);
        add(0,0,16'h0000,1, 1,16'h8000,0,1,0);
        add(0,0,16'h0000,1, 0,16'h8000,0,1,0);
        add(0,0,16'h0000,0, 0,16'h8000,0,1,0);
        // underrun, then late sample
        for (int i = 0; i < 5; i++) add(0,0,16'h0000,1, 0,16'h8000,0,1,1);
        add(0,1,16'h1234,1, 0,16'h8000,1,1,1);
        add(0,0,16'h0000,1, 1,16'h1234,0,1,1);
        add(0,0,16'h0000,1, 0,16'h1234,0,1,1);
        add(0,0,16'h0000,0, 0,16'h1234,0,1,1);
        // fill to full, overflow dropped, request at full
        add(0,1,16'h1111,0, 0,16'h1234,1,1,1);
        add(0,1,16'h2222,0, 0,16'h1234,2,1,1);
        add(0,1,16'h3333,0, 0,16'h1234,3,1,1);
        add(0,1,16'h4444,0, 0,16'h1234,4,0,1);
        add(0,1,16'h5555,0, 0,16'h1234,4,0,1);
        add(0,1,16'hBEEF,1, 1,16'h1111,3,1,1);
        add(0,0,16'h0000,1, 0,16'h1111,3,1,1);
        add(0,0,16'h0000,0, 0,16'h1111,3,1,1);
        add(0,0,16'h0000,1, 1,16'h2222,2,1,1);
        add(0,0,16'h0000,1, 0,16'h2222,2,1,1);
        add(0,0,16'h0000,0, 0,16'h2222,2,1,1);
        add(0,0,16'h0000,1, 1,16'h3333,1,1,1);
        add(0,0,16'h0000,1, 0,16'h3333,1,1,1);
        add(0,0,16'h0000,0, 0,16'h3333,1,1,1);
        add(0,0,16'h0000,1, 1,16'h4444,0,1,1);
        add(0,0,16'h0000,1, 0,16'h4444,0,1,1);
        add(0,0,16'h0000,0, 0,16'h4444,0,1,1);
        add(0,0,16'h0000,1, 0,16'h4444,0,1,1);
        add(0,0,16'h0000,0, 0,16'h4444,0,1,1);
        // reset while ack is high with two samples left
        add(0,1,16'h0AAA,0, 0,16'h4444,1,1,1);
        add(0,1,16'h0BBB,0, 0,16'h4444,2,1,1);
        add(0,1,16'h0CCC,0, 0,16'h4444,3,1,1);
        add(0,0,16'h0000,1, 1,16'h0AAA,2,1,1);
        add(1,0,16'h0000,1, 0,16'h0000,0,1,0);
        add(0,0,16'h0000,0, 0,16'h0000,0,1,0);
        add(0,0,16'h0000,1, 0,16'h0000,0,1,1);
        // withdrawn request loses the popped sample
        add(0,1,16'h0DDD,0, 0,16'h0000,1,1,1);
        add(0,0,16'h0000,1, 1,16'h0DDD,0,1,1);
        add(0,0,16'h0000,0, 0,16'h0DDD,0,1,1);
        add(0,0,16'h0000,1, 0,16'h0DDD,0,1,1);
        add(0,0,16'h0000,0, 0,16'h0DDD,0,1,1);

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; in_valid = vt[i].iv; in_data = vt[i].d; req = vt[i].rq;
            step();
            check($sformatf("v%0d_ack", i),      32'(ack),      32'(vt[i].e_ack));
            check($sformatf("v%0d_data", i),     32'(data_out), 32'(vt[i].e_data));
            check($sformatf("v%0d_level", i),    32'(level),    32'(vt[i].e_lvl));
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            check($sformatf("v%0d_underrun", i), 32'(underrun), 32'(vt[i].e_und));
        end

        // soak: filter-like requester paced by L=160, M=147
        rst = 1'b1; in_valid = 1'b0; req = 1'b0;
        step(); step();
        rst = 1'b0;
        m_und = 1'b0; acc = 0; rq_st = 0; pushed = 0; got = 0; exp_d = '0;
        for (int cyc = 0; cyc < 30000 && got < 1000; cyc++) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (rq_st == 0) begin
                acc += 147;
                if (acc >= 160) begin
                    acc -= 160;
                    rq_st = 1;
                end
            end
            req = (rq_st == 1) || (rq_st == 2);

            m_pop  = (rq_st == 1) && (q.size() > 0);
            if (rq_st == 1 && q.size() == 0) m_und = 1'b1;
            m_push = in_valid && (q.size() < 4);
            if (m_pop) exp_d = q.pop_front();
            if (m_push) begin
                q.push_back(in_data);
                pushed++;
            end

            step();

            check("soak_ack",      32'(ack),      32'(m_pop));
            check("soak_level",    32'(level),    32'(q.size()));
            check("soak_in_ready", 32'(in_ready), 32'(q.size() != 4));
            check("soak_underrun", 32'(underrun), 32'(m_und));
            if (m_pop || rq_st == 2) check("soak_data", 32'(data_out), 32'(exp_d));

            if (rq_st == 2) begin
                got++;
                rq_st = 3;
            end else if (rq_st == 3) begin
                rq_st = 0;
            end else if (rq_st == 1 && m_pop) begin
                rq_st = 2;
            end
        end
        tests++;
        if (got != 1000) begin
            fails++;
            $display("FAIL soak_delivered: got %0d expected %0d", got, 1000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
